// File: rtl/lutram_fifo.sv
// Single-clock FIFO over a distributed-RAM array with an asynchronous read port.
// Define LUTRAM_FIFO_OREG_EN to put a registered output stage after the array.
module lutram_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  WCLK,
  input  logic                  RST,
  input  logic                  WE,
  input  logic [WIDTH-1:0]      D,
  output logic                  FULL,
  input  logic                  RE,
  output logic [WIDTH-1:0]      Q,
  output logic                  EMPTY,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  OVF,
  output logic                  UDF
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  arr_pop;

  // Reset overrides any request presented on the same edge.
  assign FULL   = (count == DEPTH_C);
  assign wr_acc = WE && !FULL && !RST;
  assign rd_acc = RE && !EMPTY && !RST;
  assign COUNT  = count;

  always_comb begin
    count_next = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge WCLK) begin
    if (wr_acc) begin
      mem[wr_ptr] <= D;
    end
  end

  always_ff @(posedge WCLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      OVF    <= 1'b0;
      UDF    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (arr_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      OVF   <= WE && FULL;
      UDF   <= RE && EMPTY;
    end
  end

`ifdef LUTRAM_FIFO_OREG_EN
  logic [WIDTH-1:0] oreg;
  logic             oreg_valid;
  logic             arr_empty;

  // COUNT includes the output register, so the array holds COUNT - oreg_valid entries.
  assign arr_empty = (count == (DEPTH_LOG2 + 1)'(oreg_valid));
  assign arr_pop   = (!oreg_valid || rd_acc) && !arr_empty && !RST;
  assign EMPTY     = !oreg_valid;
  assign Q         = oreg;

  always_ff @(posedge WCLK) begin
    if (RST) begin
      oreg_valid <= 1'b0;
    end else if (arr_pop) begin
      oreg       <= mem[rd_ptr];
      oreg_valid <= 1'b1;
    end else if (rd_acc) begin
      oreg_valid <= 1'b0;
    end
  end
`else
  assign arr_pop = rd_acc;
  assign EMPTY   = (count == '0);
  assign Q       = mem[rd_ptr];
`endif

endmodule

// File: tb/tb_lutram_fifo.sv
// Directed self-checking bench for lutram_fifo (WIDTH=8, DEPTH_LOG2=2).
// Follows LUTRAM_FIFO_OREG_EN to pick the expected EMPTY-deassert latency.
module tb_lutram_fifo;

`ifdef LUTRAM_FIFO_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       wclk;
  logic       rst;
  logic       we;
  logic [7:0] d;
  logic       full;
  logic       re;
  logic [7:0] q;
  logic       empty;
  logic [2:0] count;
  logic       ovf;
  logic       udf;

  int checks;
  int failures;

  lutram_fifo #(.WIDTH(8), .DEPTH_LOG2(2)) dut (
    .WCLK(wclk), .RST(rst), .WE(we), .D(d), .FULL(full), .RE(re),
    .Q(q), .EMPTY(empty), .COUNT(count), .OVF(ovf), .UDF(udf)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; re = 1'b0; d = 8'h00;
    tick(); tick();
    rst = 1'b0;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if ({ovf, udf} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {ovf, udf}); end
    $display("test_reset done");
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin
      we = 1'b1; d = vals[k];
      tick();
      if (k == 0) begin
        checks++; if (empty !== (LAT == 2)) begin failures++; $display("FAIL fill_empty_latency got=%b exp=%b", empty, (LAT == 2)); end
      end
    end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
    d = 8'h55;
    tick();
    we = 1'b0;
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", ovf); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", count); end
    tick();
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (empty !== 1'b0 || q !== vals[k]) begin failures++; $display("FAIL drain_q%0d got=%h empty=%b exp=%h", k, q, empty, vals[k]); end
      $display("read %0d q=%h", k, q);
      re = 1'b1;
      tick();
      re = 1'b0;
    end
    checks++; if (empty !== 1'b1 || count !== 3'd0) begin failures++; $display("FAIL drain_end got empty=%b count=%0d exp empty=1 count=0", empty, count); end
    re = 1'b1;
    tick();
    re = 1'b0;
    checks++; if (udf !== 1'b1 || count !== 3'd0) begin failures++; $display("FAIL udf_empty got udf=%b count=%0d exp udf=1 count=0", udf, count); end
    $display("test_fill_drain done");
  endtask

  task automatic test_empty_rw();
    re = 1'b1; we = 1'b1; d = 8'hA5;
    tick();
    re = 1'b0; we = 1'b0;
    checks++; if (udf !== 1'b1) begin failures++; $display("FAIL erw_udf got=%b exp=1", udf); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL erw_count got=%0d exp=1", count); end
    checks++; if (empty !== (LAT == 2)) begin failures++; $display("FAIL erw_empty_latency got=%b exp=%b", empty, (LAT == 2)); end
    repeat (LAT - 1) tick();
    checks++; if (empty !== 1'b0 || q !== 8'hA5) begin failures++; $display("FAIL erw_q got=%h empty=%b exp=a5", q, empty); end
    re = 1'b1;
    tick();
    re = 1'b0;
    checks++; if (count !== 3'd0 || empty !== 1'b1 || udf !== 1'b0) begin failures++; $display("FAIL erw_read got count=%0d empty=%b udf=%b exp 0 1 0", count, empty, udf); end
    $display("test_empty_rw done");
  endtask

  task automatic test_full_rw();
    for (int k = 1; k <= 4; k++) begin
      we = 1'b1; d = 8'(k);
      tick();
    end
    checks++; if (full !== 1'b1 || q !== 8'h01) begin failures++; $display("FAIL frw_pre got full=%b q=%h exp 1 01", full, q); end
    re = 1'b1; d = 8'h99;
    tick();
    re = 1'b0; we = 1'b0;
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL frw_ovf got=%b exp=1", ovf); end
    checks++; if (count !== 3'd3 || full !== 1'b0) begin failures++; $display("FAIL frw_count got count=%0d full=%b exp 3 0", count, full); end
    for (int k = 2; k <= 4; k++) begin
      checks++; if (empty !== 1'b0 || q !== 8'(k)) begin failures++; $display("FAIL frw_q%0d got=%h empty=%b exp=%h", k, q, empty, 8'(k)); end
      re = 1'b1;
      tick();
      re = 1'b0;
    end
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin failures++; $display("FAIL frw_end got count=%0d empty=%b exp 0 1", count, empty); end
    $display("test_full_rw done");
  endtask

  task automatic test_stream();
    we = 1'b1; d = 8'd0; tick();
    d = 8'd1; tick();
    we = 1'b0;
    checks++; if (count !== 3'd2 || empty !== 1'b0) begin failures++; $display("FAIL stream_pre got count=%0d empty=%b exp 2 0", count, empty); end
    for (int i = 0; i < 18; i++) begin
      checks++; if (q !== 8'(i)) begin failures++; $display("FAIL stream_q%0d got=%h exp=%h", i, q, 8'(i)); end
      we = 1'b1; re = 1'b1; d = 8'(i + 2);
      tick();
      checks++; if (count !== 3'd2) begin failures++; $display("FAIL stream_count%0d got=%0d exp=2", i, count); end
    end
    we = 1'b0;
    for (int i = 18; i < 20; i++) begin
      checks++; if (empty !== 1'b0 || q !== 8'(i)) begin failures++; $display("FAIL stream_tail%0d got=%h empty=%b exp=%h", i, q, empty, 8'(i)); end
      tick();
    end
    re = 1'b0;
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin failures++; $display("FAIL stream_end got count=%0d empty=%b exp 0 1", count, empty); end
    $display("test_stream done");
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      we = 1'b1; d = 8'(8'h31 + k);
      tick();
    end
    rst = 1'b1; d = 8'h66;
    tick();
    rst = 1'b0; we = 1'b0;
    checks++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL rmid_state got count=%0d empty=%b full=%b exp 0 1 0", count, empty, full); end
    we = 1'b1; d = 8'h7E;
    tick();
    we = 1'b0;
    repeat (LAT - 1) tick();
    checks++; if (empty !== 1'b0 || q !== 8'h7E || count !== 3'd1) begin failures++; $display("FAIL rmid_q got q=%h empty=%b count=%0d exp 7e 0 1", q, empty, count); end
    re = 1'b1;
    tick();
    re = 1'b0;
    checks++; if (empty !== 1'b1 || count !== 3'd0) begin failures++; $display("FAIL rmid_end got empty=%b count=%0d exp 1 0", empty, count); end
    $display("test_reset_mid done");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; we = 1'b0; re = 1'b0; d = 8'h00;
    test_reset();
    test_fill_drain();
    test_empty_rw();
    test_full_rw();
    test_stream();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
